lottery_round_ctrl: RTL and testbench

LOTTERY_ROUND_CTRL -- requirements
Module: lottery_round_ctrl

---
 rtl/lottery_round_ctrl.sv | 139 +++++++++++++
 tb/tb_lottery_round_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lottery_round_ctrl.sv
// Lottery round controller: registers up to 32 entrants, draws a winner
// with a 6-bit LFSR, and holds the result until acknowledged.
module lottery_round_ctrl #(
    parameter int DRAW_TIMEOUT = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       entry_valid,
    input  logic       entry_bit,
    output logic       entry_ready,
    output logic [4:0] entry_id,
    input  logic       close,
    input  logic [5:0] seed,
    input  logic       ack,
    output logic [5:0] count,
    output logic       full,
    output logic [1:0] state,
    output logic [4:0] winner,
    output logic       winner_valid,
    output logic       no_winner
);

    localparam int TW = $clog2(DRAW_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REG      = 2'd1,
        DRAW     = 2'd2,
        ANNOUNCE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     queue_q;
    logic [5:0]      count_q;
    logic [5:0]      lfsr_q;
    logic [TW-1:0]   timer_q;
    logic [4:0]      winner_q;
    logic            winner_valid_q;
    logic            no_winner_q;

    logic            accept;
    logic            hit;
    logic            timeout;
    logic            empty_close;
    logic [4:0]      candidate;

    assign full         = (count_q == 6'd32);
    assign count        = count_q;
    assign entry_id     = count_q[4:0];
    assign state        = state_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;
    assign no_winner    = no_winner_q;
    assign entry_ready  = (state_q == REG) && !full;
    assign candidate    = lfsr_q[4:0];

    // Handshake, draw-hit and timeout decode plus next-state selection
    always_comb begin
        state_d     = state_q;
        accept      = entry_valid && entry_ready;
        hit         = ({1'b0, candidate} < count_q) && queue_q[candidate];
        timeout     = (timer_q == TW'(DRAW_TIMEOUT - 1));
        empty_close = close && (count_q == 6'd0) && !accept;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = REG;
            end
            REG: begin
                if (empty_close)
                    state_d = ANNOUNCE;
                else if (close)
                    state_d = DRAW;
                else if (accept && (count_q == 6'd31))
                    state_d = DRAW;
            end
            DRAW: begin
                if (hit || timeout) state_d = ANNOUNCE;
            end
            ANNOUNCE: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Round datapath: entry queue, count, LFSR, timer and result flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            queue_q        <= '0;
            count_q        <= '0;
            lfsr_q         <= 6'b000001;
            timer_q        <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            no_winner_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        queue_q        <= '0;
                        count_q        <= '0;
                        timer_q        <= '0;
                        winner_q       <= '0;
                        winner_valid_q <= 1'b0;
                        no_winner_q    <= 1'b0;
                        lfsr_q         <= (seed == 6'd0) ? 6'b000001 : seed;
                    end
                end
                REG: begin
                    if (accept) begin
                        queue_q[count_q[4:0]] <= entry_bit;
                        count_q               <= count_q + 6'd1;
                    end
                    if (empty_close) no_winner_q <= 1'b1;
                end
                DRAW: begin
                    if (hit) begin
                        winner_q       <= candidate;
                        winner_valid_q <= 1'b1;
                    end else begin
                        lfsr_q  <= {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
                        timer_q <= timer_q + TW'(1);
                        if (timeout) no_winner_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lottery_round_ctrl.sv
// Self-checking bench for lottery_round_ctrl: table-driven rounds with a
// scoreboard of expected results, plus hand sequences for reset corners.
module tb_lottery_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       entry_valid = 1'b0;
    logic       entry_bit = 1'b0;
    logic       entry_ready;
    logic [4:0] entry_id;
    logic       close = 1'b0;
    logic [5:0] seed = 6'd0;
    logic       ack = 1'b0;
    logic [5:0] count;
    logic       full;
    logic [1:0] state;
    logic [4:0] winner;
    logic       winner_valid;
    logic       no_winner;

    int total = 0;
    int bad = 0;

    lottery_round_ctrl #(.DRAW_TIMEOUT(128)) dut (
        .clk(clk), .reset(reset), .start(start),
        .entry_valid(entry_valid), .entry_bit(entry_bit),
        .entry_ready(entry_ready), .entry_id(entry_id),
        .close(close), .seed(seed), .ack(ack), .count(count),
        .full(full), .state(state), .winner(winner),
        .winner_valid(winner_valid), .no_winner(no_winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  seed;
        int          n;
        logic [31:0] bits;
        bit          close_last;
        int          wv;
        int          nw;
        int          win;
        int          cyc;
    } vec_t;

    typedef struct {
        int wv;
        int nw;
        int win;
        int cyc;
        int cnt;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_round(input vec_t v);
        exp_t e;
        int   cyc;
        e.wv  = v.wv;
        e.nw  = v.nw;
        e.win = v.win;
        e.cyc = v.cyc;
        e.cnt = v.n;
        sb.push_back(e);
        seed  = v.seed;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("reg_state", state, 1);
        chk("reg_count0", count, 0);
        for (int i = 0; i < v.n; i++) begin
            chk("entry_id", entry_id, i);
            chk("entry_ready", entry_ready, 1);
            entry_valid = 1'b1;
            entry_bit   = v.bits[i];
            close       = v.close_last && (i == v.n - 1);
            tick();
            close = 1'b0;
        end
        if (v.n == 32) begin
            chk("full", full, 1);
            chk("full_ready", entry_ready, 0);
            chk("full_state", state, 2);
        end else begin
            entry_valid = 1'b0;
            if (!v.close_last || v.n == 0) begin
                close = 1'b1;
                tick();
                close = 1'b0;
            end
        end
        cyc = 0;
        while (state == 2'd2 && cyc < 400) begin
            tick();
            cyc++;
        end
        entry_valid = 1'b0;
        e = sb.pop_front();
        chk("ann_state", state, 3);
        chk("draw_cycles", cyc, e.cyc);
        chk("winner_valid", winner_valid, e.wv);
        chk("no_winner", no_winner, e.nw);
        chk("winner", winner, e.win);
        chk("ann_count", count, e.cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ann_ignores_start", state, 3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_after_ack", state, 0);
        chk("winner_held", winner, e.win);
        chk("wv_held", winner_valid, e.wv);
    endtask

    initial begin
        vecs[0] = '{6'd2,  4,  32'h0000_000F, 1'b0, 1, 0, 2, 1};
        vecs[1] = '{6'd0,  3,  32'h0000_0002, 1'b1, 1, 0, 1, 1};
        vecs[2] = '{6'd9,  0,  32'h0000_0000, 1'b0, 0, 1, 0, 0};
        vecs[3] = '{6'd5,  5,  32'h0000_0000, 1'b0, 0, 1, 0, 128};
        vecs[4] = '{6'd40, 4,  32'h0000_000F, 1'b1, 1, 0, 3, 3};
        vecs[5] = '{6'd3,  8,  32'h0000_0040, 1'b0, 1, 0, 6, 2};
        vecs[6] = '{6'd7,  32, 32'hFFFF_FFFF, 1'b0, 1, 0, 7, 1};

        #3;
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_wv", winner_valid, 0);
        chk("rst_nw", no_winner, 0);
        chk("rst_ready", entry_ready, 0);
        reset = 1'b1;
        tick();
        ack   = 1'b1;
        close = 1'b1;
        tick();
        ack   = 1'b0;
        close = 1'b0;
        chk("idle_ignores_ack_close", state, 0);

        foreach (vecs[k]) run_round(vecs[k]);

        seed  = 6'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        entry_valid = 1'b1;
        entry_bit   = 1'b1;
        tick();
        entry_valid = 1'b0;
        tick();
        chk("winner_cleared_on_start", winner, 0);
        entry_valid = 1'b1;
        entry_bit   = 1'b0;
        tick();
        tick();
        entry_valid = 1'b0;
        close       = 1'b1;
        tick();
        close = 1'b0;
        chk("mid_draw_state", state, 2);
        for (int i = 0; i < 5; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_count", count, 0);
        chk("async_wv", winner_valid, 0);
        chk("async_nw", no_winner, 0);
        chk("async_winner", winner, 0);
        chk("async_full", full, 0);
        chk("async_ready", entry_ready, 0);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_idle", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
